// File: rtl/imem_prog_loader.sv
// rtl/imem_prog_loader.sv - length-prefixed byte-stream loader into instruction memory
module imem_prog_loader #(
    parameter int AW        = 8,
    parameter int BOOT_HOLD = 1
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_load_req,
    input  logic          i_byte_valid,
    input  logic [7:0]    i_byte,
    output logic          o_byte_ready,
    output logic          o_imem_we,
    output logic [AW-1:0] o_imem_addr,
    output logic [31:0]   o_imem_wdata,
    output logic          o_core_rstn,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [AW:0]   o_word_cnt
);

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, DONE, ERR} state_t;

    localparam logic [16:0] MAX_WORDS      = 17'(1) << AW;
    localparam logic        CORE_RSTN_INIT = (BOOT_HOLD == 0);

    state_t        state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [1:0]    idx_q, idx_d;
    logic [23:0]   asm_q, asm_d;
    logic          ready_q, ready_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          core_rstn_q, core_rstn_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [AW:0]   cnt_q, cnt_d;

    logic          accept;
    logic [16:0]   n_full;
    logic [16:0]   cnt_next;

    assign accept   = i_byte_valid && ready_q;
    // Full length as seen while the high byte is being accepted in LEN1
    assign n_full   = {1'b0, i_byte, len_q[7:0]};
    assign cnt_next = 17'(cnt_q) + 17'd1;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        asm_d       = asm_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        core_rstn_d = core_rstn_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (i_load_req) begin
                    state_d     = LEN0;
                    core_rstn_d = 1'b0;
                    busy_d      = 1'b1;
                    err_d       = 1'b0;
                    cnt_d       = '0;
                    idx_d       = '0;
                end
            end
            LEN0: begin
                if (accept) begin
                    len_d[7:0] = i_byte;
                    state_d    = LEN1;
                end
            end
            LEN1: begin
                if (accept) begin
                    len_d[15:8] = i_byte;
                    if (n_full == 17'd0) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                        core_rstn_d = 1'b1;
                    end else if (n_full > MAX_WORDS) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    idx_d = idx_q + 2'd1;
                    case (idx_q)
                        2'd0: asm_d[7:0]   = i_byte;
                        2'd1: asm_d[15:8]  = i_byte;
                        2'd2: asm_d[23:16] = i_byte;
                        default: begin
                            we_d    = 1'b1;
                            addr_d  = cnt_q[AW-1:0];
                            wdata_d = {i_byte, asm_q};
                            cnt_d   = cnt_q + 1'b1;
                            if (cnt_next == {1'b0, len_q}) begin
                                state_d     = DONE;
                                done_d      = 1'b1;
                                busy_d      = 1'b0;
                                core_rstn_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase

        // Ready is registered, so it is derived from where the FSM is heading
        ready_d = (state_d == LEN0) || (state_d == LEN1) || (state_d == DATA);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            asm_q       <= '0;
            ready_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            core_rstn_q <= CORE_RSTN_INIT;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            asm_q       <= asm_d;
            ready_q     <= ready_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            core_rstn_q <= core_rstn_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign o_byte_ready = ready_q;
    assign o_imem_we    = we_q;
    assign o_imem_addr  = addr_q;
    assign o_imem_wdata = wdata_q;
    assign o_core_rstn  = core_rstn_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_err        = err_q;
    assign o_word_cnt   = cnt_q;

endmodule

// File: tb/tb_imem_prog_loader.sv
// tb/tb_imem_prog_loader.sv - directed self-checking bench for imem_prog_loader
module tb_imem_prog_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          load_req = 1'b0;
    logic          bv = 1'b0;
    logic [7:0]    bt = 8'h00;
    logic          ready, we, core_rstn, busy, done, err;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [AW:0]   word_cnt;

    imem_prog_loader #(.AW(AW), .BOOT_HOLD(1)) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_load_req   (load_req),
        .i_byte_valid (bv),
        .i_byte       (bt),
        .o_byte_ready (ready),
        .o_imem_we    (we),
        .o_imem_addr  (addr),
        .o_imem_wdata (wdata),
        .o_core_rstn  (core_rstn),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    int            n_chk = 0;
    int            n_fail = 0;
    int            wait_total = 0;
    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];
    logic [7:0]    img[$];

    always @(negedge clk) begin
        if (we) begin
            wr_addr.push_back(addr);
            wr_data.push_back(wdata);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_load;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap, input bit lr);
        int w;
        w = 0;
        if (gap) begin
            bv = 1'b0;
            tick();
        end
        bt       = b;
        bv       = 1'b1;
        load_req = lr;
        while (!ready && w < 20) begin
            tick();
            w++;
        end
        wait_total += w;
        if (w >= 20) chk("ready_timeout", 64'd0, 64'd1);
        tick();
        bv       = 1'b0;
        load_req = 1'b0;
    endtask

    task automatic send_range(input int from, input int to, input bit rnd, input bit lr_in_data);
        for (int i = from; i <= to; i++)
            send_byte(img[i], rnd ? bit'($urandom_range(0, 1)) : 1'b0,
                      lr_in_data && (i >= 3) && (i % 3 == 0));
    endtask

    task automatic set_main_image;
        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'ha0, 8'h00};
    endtask

    task automatic chk_main_writes(input string tag, input int base);
        chk({tag, "_nwr"}, 64'(wr_addr.size()), 64'(base + 2));
        if (wr_addr.size() == base + 2) begin
            chk({tag, "_a0"}, 64'(wr_addr[base]),     64'h0);
            chk({tag, "_d0"}, 64'(wr_data[base]),     64'h00500513);
            chk({tag, "_a1"}, 64'(wr_addr[base + 1]), 64'h1);
            chk({tag, "_d1"}, 64'(wr_data[base + 1]), 64'h00a00593);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        // 1: reset and idle with a byte pending
        bv = 1'b1;
        bt = 8'hff;
        repeat (3) tick();
        chk("rst_core_rstn", 64'(core_rstn), 64'd0);
        chk("rst_ready",     64'(ready),     64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_done",      64'(done),      64'd0);
        chk("rst_err",       64'(err),       64'd0);
        chk("rst_word_cnt",  64'(word_cnt),  64'd0);
        chk("rst_wdata",     64'(wdata),     64'd0);
        rstn = 1'b1;
        repeat (5) tick();
        chk("idle_nwr",   64'(wr_addr.size()), 64'd0);
        chk("idle_ready", 64'(ready),          64'd0);
        chk("idle_core",  64'(core_rstn),      64'd0);
        bv = 1'b0;

        // 2: two-word image at full rate
        set_main_image();
        pulse_load();
        chk("ld_busy",  64'(busy),      64'd1);
        chk("ld_core",  64'(core_rstn), 64'd0);
        chk("ld_ready", 64'(ready),     64'd1);
        wait_total = 0;
        send_range(0, 9, 1'b0, 1'b0);
        chk("full_done",  64'(done),      64'd1);
        chk("full_core",  64'(core_rstn), 64'd1);
        chk("full_cnt",   64'(word_cnt),  64'd2);
        chk("full_busy",  64'(busy),      64'd0);
        chk("full_wait",  64'(wait_total), 64'd0);
        chk_main_writes("full", 0);
        tick();
        chk("full_done_pulse", 64'(done),      64'd0);
        chk("full_core_hold",  64'(core_rstn), 64'd1);
        chk("full_ready_off",  64'(ready),     64'd0);

        // 3: same image with random valid gaps
        wr_addr.delete();
        wr_data.delete();
        pulse_load();
        wait_total = 0;
        send_range(0, 9, 1'b1, 1'b0);
        chk("gap_done", 64'(done),       64'd1);
        chk("gap_cnt",  64'(word_cnt),   64'd2);
        chk("gap_wait", 64'(wait_total), 64'd0);
        chk_main_writes("gap", 0);

        // 4: zero length and oversize length
        wr_addr.delete();
        wr_data.delete();
        img = '{8'h00, 8'h00};
        pulse_load();
        send_range(0, 1, 1'b0, 1'b0);
        chk("zero_done", 64'(done),           64'd1);
        chk("zero_core", 64'(core_rstn),      64'd1);
        chk("zero_cnt",  64'(word_cnt),       64'd0);
        chk("zero_nwr",  64'(wr_addr.size()), 64'd0);
        img = '{8'h01, 8'h01};
        pulse_load();
        chk("big_core_drop", 64'(core_rstn), 64'd0);
        send_range(0, 1, 1'b0, 1'b0);
        chk("big_err",  64'(err),       64'd1);
        chk("big_busy", 64'(busy),      64'd0);
        chk("big_done", 64'(done),      64'd0);
        chk("big_core", 64'(core_rstn), 64'd0);
        repeat (3) tick();
        chk("big_err_sticky", 64'(err),            64'd1);
        chk("big_ready",      64'(ready),          64'd0);
        chk("big_nwr",        64'(wr_addr.size()), 64'd0);
        pulse_load();
        chk("err_clear", 64'(err),  64'd0);
        chk("err_busy",  64'(busy), 64'd1);

        // 5: stray load requests during DATA, then a one-word reload
        set_main_image();
        send_range(0, 9, 1'b0, 1'b1);
        chk("lr_done", 64'(done),     64'd1);
        chk("lr_cnt",  64'(word_cnt), 64'd2);
        chk_main_writes("lr", 0);
        wr_addr.delete();
        wr_data.delete();
        img = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        pulse_load();
        send_range(0, 5, 1'b0, 1'b0);
        chk("one_done", 64'(done),           64'd1);
        chk("one_cnt",  64'(word_cnt),       64'd1);
        chk("one_nwr",  64'(wr_addr.size()), 64'd1);
        if (wr_addr.size() == 1) begin
            chk("one_addr", 64'(wr_addr[0]), 64'h0);
            chk("one_data", 64'(wr_data[0]), 64'h12345678);
        end

        // 6: reset in the middle of the second word
        wr_addr.delete();
        wr_data.delete();
        set_main_image();
        pulse_load();
        send_range(0, 6, 1'b0, 1'b0);
        chk("mid_nwr",  64'(wr_addr.size()), 64'd1);
        chk("mid_busy", 64'(busy),           64'd1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(ready),     64'd0);
        chk("mid_rst_busy",  64'(busy),      64'd0);
        chk("mid_rst_core",  64'(core_rstn), 64'd0);
        chk("mid_rst_cnt",   64'(word_cnt),  64'd0);
        chk("mid_rst_wdata", 64'(wdata),     64'd0);
        chk("mid_rst_we",    64'(we),        64'd0);
        tick();
        rstn = 1'b1;
        repeat (3) tick();
        chk("mid_after_nwr", 64'(wr_addr.size()), 64'd1);
        pulse_load();
        send_range(0, 9, 1'b0, 1'b0);
        chk("re_done", 64'(done),      64'd1);
        chk("re_core", 64'(core_rstn), 64'd1);
        chk_main_writes("re", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_prog_loader.md
Name: imem_prog_loader

Overview:
- Byte-stream writer for the core's instruction memory, the write side of the interface the instruction-fetch stage reads.
- Accepts a length-prefixed program image over a valid/ready byte channel and assembles little-endian 32-bit words.
- Drives a word-addressed write port into instruction memory.
- Holds the core in reset while loading and releases it when the image is complete.

Parameters:
AW, 8, instruction-memory word-address width (capacity 2^AW words)
BOOT_HOLD, 1, 1 = core held in reset from power-up until the first successful load; 0 = core runs out of reset

Ports:
i_clk  input  1  clock, rising edge
i_rstn  input  1  asynchronous active-low reset
i_load_req  input  1  single-cycle pulse that starts a load
i_byte_valid  input  1  byte channel valid
i_byte  input  8  byte channel data
o_byte_ready  output  1  byte channel ready
o_imem_we  output  1  instruction-memory write enable, one-cycle pulse per word
o_imem_addr  output  AW  word address of the write
o_imem_wdata  output  32  write data
o_core_rstn  output  1  active-low reset to the core
o_busy  output  1  load in progress
o_done  output  1  one-cycle pulse when a load completes
o_err  output  1  sticky length error, cleared by the next i_load_req
o_word_cnt  output  AW+1  words written in the current or last load

Behaviour:
- Reset values (asynchronous, i_rstn low):
  - state IDLE; o_byte_ready, o_imem_we, o_busy, o_done, o_err = 0.
  - o_imem_addr, o_imem_wdata, o_word_cnt, internal length and byte index = 0.
  - o_core_rstn = ~BOOT_HOLD.
- All outputs are registered. A byte transfers on a rising edge with i_byte_valid && o_byte_ready.
- States: IDLE, LEN0, LEN1, DATA, DONE, ERR.
- IDLE / DONE / ERR:
  - o_byte_ready = 0.
  - i_load_req -> LEN0 next cycle; in that same cycle o_core_rstn = 0, o_busy = 1, o_err = 0, o_word_cnt = 0, byte index = 0.
- LEN0: ready = 1; the accepted byte becomes length N[7:0] -> LEN1.
- LEN1: ready = 1; the accepted byte becomes N[15:8]. Next state:
  - N == 0 -> DONE.
  - N > 2^AW -> ERR.
  - otherwise -> DATA.
- DATA: ready = 1. Bytes fill bits [7:0], [15:8], [23:16], [31:24] in order (byte index 0..3, wraps to 0).
- On acceptance of byte index 3 at edge T:
  - in cycle T+1: o_imem_we = 1, o_imem_addr = o_word_cnt (pre-increment), o_imem_wdata = assembled word; o_word_cnt increments.
  - ready stays 1 in T+1, so back-to-back bytes at full rate are legal. The assembly register is separate from o_imem_wdata.
  - if this was word N, state = DONE in cycle T+1.
- Entry to DONE (any path): o_done = 1 and o_busy = 0 for one cycle. o_core_rstn rises in the same cycle as o_done. Exception: N > 2^AW never reaches DONE.
- Entry to ERR: o_err = 1, o_busy = 0, o_core_rstn stays 0, no writes issued.
- i_load_req while busy (LEN0/LEN1/DATA) is ignored.
- i_byte_valid while ready = 0 is not consumed. The source must hold the byte.
- Address never wraps: N ≤ 2^AW is enforced before DATA. o_word_cnt reaches at most 2^AW, hence width AW+1.
- Reset mid-load: all registers return to reset values. Words already written stay in memory. o_core_rstn returns to ~BOOT_HOLD.
- o_imem_we is never asserted outside DATA-completion cycles. At most one write per 4 accepted data bytes.

Test Plan:
1. Reset with BOOT_HOLD=1 -> o_core_rstn=0, o_byte_ready=0, o_busy=0; no writes while idle even with i_byte_valid=1.
2. AW=8, load_req, then bytes 02 00 13 05 50 00 93 05 a0 00 at full rate:
   - writes addr0=0x00500513, then addr1=0x00a00593, each a one-cycle we pulse.
   - o_done pulses the cycle after the last byte; o_core_rstn=1 that cycle; o_word_cnt=2.
3. Same image with i_byte_valid toggled randomly -> identical writes and data; ready is never low in DATA.
4. Length 00 00 -> DONE right after the second byte, zero writes, o_core_rstn=1. Length 01 01 (257 > 256) -> o_err=1, no writes, o_core_rstn stays 0. A new load_req clears o_err.
5. Extra load_req pulses during DATA are ignored; the load completes normally. After done, a second load of N=1 writes addr0 again and o_word_cnt=1.
6. Assert i_rstn low after 5 data bytes -> all outputs at reset values immediately; the partial word is not written; the next full load succeeds.
